mem_port_arbiter8: RTL

- Round-robin arbiter/sequencer sharing one memory port among up to 8 requesters (I-fetch, D-access, prefetch, debug, ...).
- Drives the 3-bit select of the existing 8:1 address/wdata mux and owns the downstream read/write strobes.
- Holds the grant for a full transaction until `mem_resp`, then routes the response back to the granted requester.
- Sits between the per-requester datapaths and the cache/memory interface.

---
 rtl/mem_port_arbiter8_pkg.sv | 16 +
 rtl/rr_pick8.sv | 27 ++
 rtl/mem_port_arbiter8.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_port_arbiter8_pkg.sv
// rtl/mem_port_arbiter8_pkg.sv - shared types and helpers for the memory port arbiter
package arb_types;

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} arb_state_t;

   localparam int ARB_MAX_REQ = 8;
   localparam int ARB_SEL_W   = 3;

   function automatic logic [ARB_MAX_REQ-1:0] onehot8(input logic [ARB_SEL_W-1:0] idx);
      logic [ARB_MAX_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin picker: first requester at or after ptr, cyclic
module rr_pick8
   import arb_types::*;
(
   input  logic [7:0] req,
   input  logic [2:0] ptr,
   output logic       valid,
   output logic [2:0] idx
);

   logic [2:0] cand;

   // Scan farthest-to-nearest so the nearest hit to ptr overwrites the rest.
   always_comb begin
      valid = 1'b0;
      idx   = ptr;
      cand  = '0;
      for (int i = ARB_MAX_REQ - 1; i >= 0; i--) begin
         cand = ptr + 3'(i);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter8.sv
// rtl/mem_port_arbiter8.sv - round-robin owner of the shared memory port (IDLE/BUSY/RELEASE)
// Define FIXED_PRIO0_EN to give requester 0 absolute priority over the round-robin.
module mem_port_arbiter8
   import arb_types::*;
#(
   parameter int NUM_REQ = 8
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req_read,
   input  logic [7:0] req_write,
   input  logic       mem_resp,
   output logic       mem_read,
   output logic       mem_write,
   output logic [2:0] sel,
   output logic [7:0] grant,
   output logic [7:0] resp,
   output logic       busy
);

   localparam logic [8:0] MASK9    = 9'((1 << NUM_REQ) - 1);
   localparam logic [7:0] REQ_MASK = MASK9[7:0];

   arb_state_t state, state_nxt;
   logic [2:0] ptr, ptr_nxt, sel_nxt;
   logic [7:0] grant_nxt;
   logic       rd_nxt, wr_nxt;

   logic [7:0] rd_v, wr_v, req, rr_req;
   logic       pick_valid, win_valid, ptr_upd;
   logic [2:0] pick_idx, win_idx;

   assign rd_v = req_read & REQ_MASK;
   assign wr_v = req_write & REQ_MASK;
   assign req  = rd_v | wr_v;

`ifdef FIXED_PRIO0_EN
   assign rr_req = {req[7:1], 1'b0};
`else
   assign rr_req = req;
`endif

   rr_pick8 u_pick (
      .req   (rr_req),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // A priority grant to requester 0 must not disturb the rotation of the others.
   always_comb begin
      win_valid = pick_valid;
      win_idx   = pick_idx;
      ptr_upd   = 1'b1;
`ifdef FIXED_PRIO0_EN
      if (req[0]) begin
         win_valid = 1'b1;
         win_idx   = 3'd0;
         ptr_upd   = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         sel       <= '0;
         grant     <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         sel       <= sel_nxt;
         grant     <= grant_nxt;
         mem_read  <= rd_nxt;
         mem_write <= wr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_valid) state_nxt = BUSY;
         BUSY:    if (mem_resp)  state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sel_nxt   = sel;
      grant_nxt = grant;
      rd_nxt    = mem_read;
      wr_nxt    = mem_write;
      ptr_nxt   = ptr;
      if (state == IDLE && win_valid) begin
         grant_nxt = onehot8(win_idx);
         sel_nxt   = win_idx;
         wr_nxt    = wr_v[win_idx];
         rd_nxt    = rd_v[win_idx] & ~wr_v[win_idx];
         if (ptr_upd)
            ptr_nxt = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
      end else if (state == BUSY && mem_resp) begin
         grant_nxt = '0;
         rd_nxt    = 1'b0;
         wr_nxt    = 1'b0;
      end
      busy = (state == BUSY);
      resp = grant & REQ_MASK & {8{mem_resp && state == BUSY}};
   end

endmodule
